// File: rtl/health_tracker.sv
// rtl/health_tracker.sv - player health bookkeeping driven by the collision detector
// Tracks health, hit strobes, invulnerability window and game-over state.
module health_tracker #(
    parameter int MAX_HEALTH = 3,
    parameter int HEALTH_W   = 4,
    parameter int INV_CYCLES = 50000000,
    parameter int INV_W      = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                health_update,
    output logic [HEALTH_W-1:0] health,
    output logic                hit_pulse,
    output logic                invuln,
    output logic                game_over,
    output logic [7:0]          hit_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIVE  = 2'd1,
        S_INVULN = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] HEALTH_ONE  = HEALTH_W'(1);
    localparam logic [INV_W-1:0]    TIMER_LOAD  = INV_W'(INV_CYCLES - 1);

    state_t              state_q;
    logic [HEALTH_W-1:0] health_q;
    logic                hit_pulse_q;
    logic                invuln_q;
    logic                game_over_q;
    logic [7:0]          hit_count_q;
    logic [INV_W-1:0]    timer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            health_q    <= HEALTH_FULL;
            hit_pulse_q <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            hit_count_q <= 8'd0;
            timer_q     <= '0;
        end else begin
            hit_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    health_q    <= HEALTH_FULL;
                    invuln_q    <= 1'b0;
                    game_over_q <= 1'b0;
                    timer_q     <= '0;
                    if (start) begin
                        state_q     <= S_ALIVE;
                        hit_count_q <= 8'd0;
                    end
                end
                S_ALIVE: begin
                    // Pausing wins over a coincident hit.
                    if (!start) begin
                        state_q  <= S_IDLE;
                        health_q <= HEALTH_FULL;
                    end else if (health_update) begin
                        health_q    <= health_q - HEALTH_ONE;
                        hit_pulse_q <= 1'b1;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_q <= hit_count_q + 8'd1;
                        end
                        if (health_q == HEALTH_ONE) begin
                            state_q     <= S_DEAD;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q  <= S_INVULN;
                            invuln_q <= 1'b1;
                            timer_q  <= TIMER_LOAD;
                        end
                    end
                end
                S_INVULN: begin
                    if (!start) begin
                        state_q  <= S_IDLE;
                        health_q <= HEALTH_FULL;
                        invuln_q <= 1'b0;
                        timer_q  <= '0;
                    end else if (timer_q == '0) begin
                        state_q  <= S_ALIVE;
                        invuln_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - INV_W'(1);
                    end
                end
                S_DEAD: begin
                    // Only a released switch leaves DEAD, so a held start cannot auto-restart.
                    health_q <= '0;
                    if (!start) begin
                        state_q     <= S_IDLE;
                        health_q    <= HEALTH_FULL;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign health    = health_q;
    assign hit_pulse = hit_pulse_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;
    assign hit_count = hit_count_q;

endmodule
